uart_rx_fifo: RTL and testbench

Receive-side buffer sitting directly downstream of the UART receiver. It captures each completed byte on the receiver's one-cycle done tick into a first-word-fall-through FIFO. It exposes the head byte and status flags to the CPU/bus side, raises a sticky overrun flag when bytes are lost, and drives an RTS-style flow-control output from a configurable fill threshold.

---
 rtl/uart_rx_fifo.sv | 101 ++++++++++
 tb/tb_uart_rx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FWFT buffer behind the UART receiver.
// Captures each byte on the receiver's done tick.
// Exposes the head byte, occupancy and status flags to the bus side.
// Keeps a sticky overrun flag for dropped bytes.
// Drives an RTS-style flow-control output from a fill threshold.
//
// Handshake: wr_tick is a push with no back-pressure (the receiver cannot
// stall), so a push into a full FIFO is dropped and flagged. rd is a pop
// request qualified by ~empty; dout is valid whenever empty=0 and the popped
// entry is replaced by the next one in the cycle after the rd edge.
module uart_rx_fifo #(
   parameter int DBIT     = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_tick,
   input  logic [DBIT-1:0]   din,
   input  logic              rd,
   input  logic              ovr_clr,
   output logic [DBIT-1:0]   dout,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overrun,
   output logic              rts_n
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AF_THR    = AF_LEVEL[ADDR_W:0];

   logic [DBIT-1:0]   mem_q [DEPTH];
   logic [ADDR_W-1:0] wp_q, wp_d;
   logic [ADDR_W-1:0] rp_q, rp_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overrun_q, overrun_d;
   logic              rts_n_q, rts_n_d;

   logic              we;
   logic              rd_eff;
   logic              drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_CNT);

   // A pop is only real when there is something to pop; a push into a full
   // FIFO is still accepted if the same cycle frees a slot.
   assign rd_eff = rd & ~empty;
   assign we     = wr_tick & (~full | rd_eff);
   assign drop   = wr_tick & full & ~rd_eff;

   // Next-state for pointers, occupancy and flags.
   always_comb begin
      wp_d      = wp_q;
      rp_d      = rp_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      if (we)     wp_d = wp_q + 1'b1;
      if (rd_eff) rp_d = rp_q + 1'b1;
      if (we && !rd_eff)      count_d = count_q + 1'b1;
      else if (!we && rd_eff) count_d = count_q - 1'b1;
      // A drop wins over a same-cycle clear so no loss goes unreported.
      if (drop)         overrun_d = 1'b1;
      else if (ovr_clr) overrun_d = 1'b0;
      rts_n_d = (count_d >= AF_THR);
   end

   // Control registers; reset discards everything, including an in-flight tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp_q      <= '0;
         rp_q      <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         rts_n_q   <= 1'b0;
      end else begin
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         rts_n_q   <= rts_n_d;
      end
   end

   // Storage array; cleared on reset so dout reads 0 straight out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[wp_q] <= din;
      end
   end

   assign dout    = mem_q[rp_q];
   assign count   = count_q;
   assign overrun = overrun_q;
   assign rts_n   = rts_n_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

   logic       clk;
   logic       reset_n;
   logic       wr_tick;
   logic [7:0] din;
   logic       rd;
   logic       ovr_clr;
   logic [7:0] dout;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overrun;
   logic       rts_n;

   int n_vec;
   int n_err;

   uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_tick (wr_tick),
      .din     (din),
      .rd      (rd),
      .ovr_clr (ovr_clr),
      .dout    (dout),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .overrun (overrun),
      .rts_n   (rts_n)
   );

   // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      wr_tick = 1'b1;
      din     = b;
      tick();
      wr_tick = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      chk(tag, dout, exp);
      rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      wr_tick = 1'b0;
      din     = 8'h00;
      rd      = 1'b0;
      ovr_clr = 1'b0;

      // Reset state, checked before any clock edge.
      #3;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_rts", rts_n, 0);
      chk("rst_dout", dout, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;

      // Three writes then three ordered reads.
      push(8'h41); push(8'h42); push(8'h43);
      chk("t1_count", count, 3);
      chk("t1_empty", empty, 0);
      pop_chk("t1_rd0", 8'h41);
      pop_chk("t1_rd1", 8'h42);
      pop_chk("t1_rd2", 8'h43);
      chk("t1_empty_end", empty, 1);
      chk("t1_count_end", count, 0);

      // rts_n threshold at 12 with no hysteresis.
      for (int i = 0; i < 11; i++) push(8'h20 + 8'(i));
      chk("rts_11", rts_n, 0);
      push(8'h2B);
      chk("rts_12", rts_n, 1);
      pop_chk("rts_rd", 8'h20);
      chk("rts_after_rd", rts_n, 0);
      for (int i = 1; i < 12; i++) pop_chk("rts_drain", 8'h20 + 8'(i));
      chk("rts_empty", empty, 1);

      // Fill to 16, then drop one byte while ovr_clr is also asserted.
      for (int i = 0; i < 16; i++) push(8'(i));
      chk("f_full", full, 1);
      chk("f_count", count, 16);
      chk("f_rts", rts_n, 1);
      chk("f_ovr0", overrun, 0);
      wr_tick = 1'b1; din = 8'hAA; ovr_clr = 1'b1;
      tick();
      wr_tick = 1'b0; ovr_clr = 1'b0;
      chk("drop_ovr_set", overrun, 1);
      chk("drop_count", count, 16);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_clr", overrun, 0);

      // Full with simultaneous push and pop: both happen, no overrun.
      chk("fwr_head", dout, 8'h00);
      wr_tick = 1'b1; din = 8'h55; rd = 1'b1;
      tick();
      wr_tick = 1'b0; rd = 1'b0;
      chk("fwr_count", count, 16);
      chk("fwr_ovr", overrun, 0);
      chk("fwr_full", full, 1);
      for (int i = 1; i < 16; i++) pop_chk("f_drain", 8'(i));
      pop_chk("f_last55", 8'h55);
      chk("f_empty", empty, 1);
      chk("f_count0", count, 0);
      chk("f_rts0", rts_n, 0);

      // rd on empty must not underflow.
      rd = 1'b1;
      tick(); tick();
      rd = 1'b0;
      chk("uf_count", count, 0);
      chk("uf_empty", empty, 1);
      push(8'h7E);
      chk("uf_count1", count, 1);
      chk("uf_dout", dout, 8'h7E);
      pop_chk("uf_rd", 8'h7E);

      // Same-cycle push and pop on empty: pop ignored.
      wr_tick = 1'b1; din = 8'h33; rd = 1'b1;
      tick();
      wr_tick = 1'b0; rd = 1'b0;
      chk("ewr_count", count, 1);
      chk("ewr_dout", dout, 8'h33);
      pop_chk("ewr_rd", 8'h33);

      // Build count=5 with overrun set, then reset between edges.
      for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
      push(8'h99);
      chk("ar_ovr", overrun, 1);
      for (int i = 0; i < 11; i++) pop_chk("ar_pop", 8'h60 + 8'(i));
      chk("ar_count5", count, 5);
      #3;
      reset_n = 1'b0;
      #1;
      chk("ar_empty", empty, 1);
      chk("ar_count", count, 0);
      chk("ar_dout", dout, 8'h00);
      chk("ar_ovr0", overrun, 0);
      // A tick arriving during reset is lost.
      wr_tick = 1'b1; din = 8'hEE;
      tick();
      wr_tick = 1'b0;
      chk("ar_tick_lost", count, 0);
      chk("ar_tick_ovr", overrun, 0);
      @(negedge clk);
      reset_n = 1'b1;
      push(8'h12);
      chk("ar_post_count", count, 1);
      chk("ar_post_dout", dout, 8'h12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
